// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds PC, requests one word per instruction, holds it until execute acks.
// Latency: instr_valid one cycle after imem_ready; pc/imem_req update the cycle after instr_ack.
// Backpressure: waits in FETCH while imem_ready=0 and in HOLD while instr_ack=0; HALT until reset.
module instruction_fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [63:0] pc,
    input  logic        instr_ack,
    input  logic        branch_taken,
    input  logic [63:0] immediate,
    output logic        misalign_err,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {RST, FETCH, HOLD, HALT} state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retire_q;
    logic        err_q;
    logic        req_q;
    logic        vld_q;

    logic [63:0] target_d;
    logic [63:0] pc_seq_d;

    // Immediate is in halfwords; the shift discards bit 63 and all sums wrap mod 2^64.
    assign target_d = pc_q + (immediate << 1);
    assign pc_seq_d = pc_q + 64'd4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RST;
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0;
            retire_q <= 32'h0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            case (state_q)
                RST: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        vld_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        retire_q <= retire_q + 32'd1;
                        vld_q    <= 1'b0;
                        // A misaligned target retires the branch but leaves pc on it.
                        if (branch_taken && (target_d[1:0] != 2'b00)) begin
                            err_q   <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            pc_q    <= branch_taken ? target_d : pc_seq_d;
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= RST;
                    req_q   <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign instr_valid  = vld_q;
    assign instruction  = instr_q;
    assign pc           = pc_q;
    assign misalign_err = err_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: scenario tasks with a fetch scoreboard and a small PC/retire model.
module tb_instruction_fetch_unit;

    localparam logic [63:0] PC0 = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        instr_ack;
    logic        branch_taken;
    logic [63:0] immediate;
    logic        misalign_err;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.PC_RESET(PC0)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .pc           (pc),
        .instr_ack    (instr_ack),
        .branch_taken (branch_taken),
        .immediate    (immediate),
        .misalign_err (misalign_err),
        .retire_count (retire_count)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_pc;
    logic [31:0] m_ret;
    logic        m_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013 ^ {a[63:48], 16'h0};
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b0; imem_ready = 1'b0; instr_ack = 1'b0; branch_taken = 1'b0;
        repeat (n) step();
        reset = 1'b1;
        step();
        m_pc = PC0; m_ret = 32'h0; m_err = 1'b0;
        sb.delete();
    endtask

    // One fetch/hold/ack transaction; DUT must be in FETCH on entry.
    task automatic fetch_one(input int waits, input int holds, input logic ack,
                             input logic br, input logic [63:0] imm);
        exp_t        e;
        logic [63:0] tgt;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            bad++;
            $display("FAIL fetch_req: req=%0b addr=%h, want req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0; imem_rdata = $urandom;
            instr_ack = 1'b1; branch_taken = (i % 2 == 1);
            step();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold: req=%0b addr=%h valid=%0b, want 1 %h 0", imem_req, imem_addr, instr_valid, m_pc);
            end
        end
        instr_ack = 1'b0; branch_taken = 1'b0;
        imem_ready = 1'b1; imem_rdata = word_at(m_pc);
        sb.push_back('{pc: m_pc, ins: word_at(m_pc)});
        step();
        imem_ready = 1'b0; imem_rdata = $urandom;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got instruction=%h with no expectation", instruction);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== e.ins || pc !== e.pc || retire_count !== m_ret) begin
            bad++;
            $display("FAIL hold_data: valid=%0b req=%0b ins=%h pc=%h ret=%0d, want 1 0 %h %h %0d",
                     instr_valid, imem_req, instruction, pc, retire_count, e.ins, e.pc, m_ret);
        end
        for (int i = 0; i < holds; i++) begin
            branch_taken = 1'b1; immediate = 64'h40;
            step();
            total++;
            if (instr_valid !== 1'b1 || instruction !== e.ins || pc !== e.pc) begin
                bad++;
                $display("FAIL hold_stable: valid=%0b ins=%h pc=%h, want 1 %h %h", instr_valid, instruction, pc, e.ins, e.pc);
            end
        end
        instr_ack = ack; branch_taken = br; immediate = imm;
        if (ack) begin
            m_ret = m_ret + 32'd1;
            if (br) begin
                tgt = m_pc + (imm << 1);
                if (tgt[1:0] != 2'b00) m_err = 1'b1;
                else                   m_pc  = tgt;
            end else begin
                m_pc = m_pc + 64'd4;
            end
        end
        step();
        instr_ack = 1'b0; branch_taken = 1'b0;
        total++;
        if (pc !== m_pc || retire_count !== m_ret || misalign_err !== m_err ||
            instr_valid !== (!ack) || imem_req !== (ack && !m_err)) begin
            bad++;
            $display("FAIL after_ack: pc=%h ret=%0d err=%0b valid=%0b req=%0b, want %h %0d %0b %0b %0b",
                     pc, retire_count, misalign_err, instr_valid, imem_req, m_pc, m_ret, m_err, !ack, ack && !m_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        instr_ack = 1'b1; branch_taken = 1'b1; immediate = 64'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== PC0 || retire_count !== 32'h0 ||
                misalign_err !== 1'b0 || instruction !== 32'h0) begin
                bad++;
                $display("FAIL reset_state: req=%0b valid=%0b pc=%h ret=%0d err=%0b ins=%h, want 0 0 %h 0 0 0",
                         imem_req, instr_valid, pc, retire_count, misalign_err, instruction, PC0);
            end
        end
        instr_ack = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
        reset = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== PC0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_req: req=%0b addr=%h valid=%0b, want 1 %h 0", imem_req, imem_addr, instr_valid, PC0);
        end
        m_pc = PC0; m_ret = 32'h0; m_err = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) fetch_one(0, 0, 1'b1, 1'b0, 64'h0);
        total++;
        if (retire_count !== 32'd3 || pc !== 64'h100C) begin
            bad++;
            $display("FAIL seq_count: ret=%0d pc=%h, want 3 100c", retire_count, pc);
        end
    endtask

    task automatic test_wait_states();
        apply_reset(2);
        fetch_one(0, 0, 1'b1, 1'b0, 64'h0);
        fetch_one(4, 2, 1'b1, 1'b0, 64'h0);
        total++;
        if (pc !== 64'h1008 || retire_count !== 32'd2) begin
            bad++;
            $display("FAIL wait_end: pc=%h ret=%0d, want 1008 2", pc, retire_count);
        end
    endtask

    task automatic test_branches();
        logic [63:0] imm;
        apply_reset(1);
        for (int i = 0; i < 4; i++) fetch_one(0, 0, 1'b1, 1'b0, 64'h0);
        fetch_one(0, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        total++;
        if (pc !== 64'h1000) begin bad++; $display("FAIL br_back: pc=%h, want 1000", pc); end
        for (int i = 0; i < 4; i++) fetch_one(0, 0, 1'b1, 1'b0, 64'h0);
        fetch_one(1, 0, 1'b1, 1'b1, 64'h10);
        total++;
        if (pc !== 64'h1030) begin bad++; $display("FAIL br_fwd: pc=%h, want 1030", pc); end
        imm = ($signed(64'hFFFF_FFFF_FFFF_FFFC) - $signed(m_pc)) >>> 1;
        fetch_one(0, 0, 1'b1, 1'b1, imm);
        total++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL br_top: pc=%h, want fffffffffffffffc", pc); end
        fetch_one(0, 1, 1'b1, 1'b0, 64'h0);
        total++;
        if (pc !== 64'h0 || imem_addr !== 64'h0) begin bad++; $display("FAIL pc_wrap: pc=%h addr=%h, want 0 0", pc, imem_addr); end
        fetch_one(0, 0, 1'b1, 1'b0, 64'h0);
    endtask

    task automatic test_misalign();
        apply_reset(1);
        fetch_one(0, 0, 1'b1, 1'b1, 64'h3);
        imem_ready = 1'b1; instr_ack = 1'b1; branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                retire_count !== 32'd1 || pc !== 64'h1000) begin
                bad++;
                $display("FAIL halt_state: err=%0b req=%0b valid=%0b ret=%0d pc=%h, want 1 0 0 1 1000",
                         misalign_err, imem_req, instr_valid, retire_count, pc);
            end
        end
        imem_ready = 1'b0; instr_ack = 1'b0;
        reset = 1'b0;
        step();
        total++;
        if (misalign_err !== 1'b0 || retire_count !== 32'h0) begin
            bad++;
            $display("FAIL halt_clear: err=%0b ret=%0d, want 0 0", misalign_err, retire_count);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset(1);
        fetch_one(0, 0, 1'b1, 1'b1, 64'h800);
        imem_ready = 1'b1; imem_rdata = word_at(64'h2000);
        step();
        imem_ready = 1'b0;
        total++;
        if (pc !== 64'h2000 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: pc=%h valid=%0b, want 2000 1", pc, instr_valid);
        end
        reset = 1'b0; instr_ack = 1'b1; branch_taken = 1'b0;
        step();
        instr_ack = 1'b0;
        total++;
        if (pc !== PC0 || instr_valid !== 1'b0 || retire_count !== 32'h0 || imem_req !== 1'b0 || instruction !== 32'h0) begin
            bad++;
            $display("FAIL mid_hold_reset: pc=%h valid=%0b ret=%0d req=%0b ins=%h, want %h 0 0 0 0",
                     pc, instr_valid, retire_count, imem_req, instruction, PC0);
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ready = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b0 || pc !== PC0) begin
            bad++;
            $display("FAIL mid_fetch_reset: valid=%0b ins=%h req=%0b pc=%h, want 0 0 0 %h",
                     instr_valid, instruction, imem_req, pc, PC0);
        end
        reset = 1'b1;
        step();
        m_pc = PC0; m_ret = 32'h0; m_err = 1'b0;
        fetch_one(0, 0, 1'b1, 1'b0, 64'h0);
    endtask

    initial begin
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        instr_ack = 1'b0; branch_taken = 1'b0; immediate = 64'h0;
        m_pc = PC0; m_ret = 32'h0; m_err = 1'b0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branches();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential fetch stage feeding the immediate generator and decode/execute logic of the processor. Holds the program counter, issues one word request per instruction to instruction memory over a req/ready handshake, and presents the fetched instruction with its PC until execute acknowledges it. On acknowledge, advances to PC+4 or to the branch target PC + (immediate << 1), where the sign-extended B-type immediate comes from the immediate generator.

## Interface
- PC_RESET, 64'h0, PC loaded on reset; must be 4-byte aligned.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  64  byte address of requested word; equals pc.
- imem_ready  input  1  memory returns imem_rdata this cycle; ignored unless imem_req=1.
- imem_rdata  input  32  instruction word; valid when imem_req & imem_ready.
- instr_valid  output  1  instruction/pc hold a fetched instruction.
- instruction  output  32  fetched instruction word, to immediate generator and decode.
- pc  output  64  address of current instruction.
- instr_ack  input  1  execute done with current instruction; ignored unless instr_valid=1.
- branch_taken  input  1  qualifies instr_ack: 1 selects branch target.
- immediate  input  64  sign-extended branch offset in halfwords, from immediate generator.
- misalign_err  output  1  sticky: a taken branch target was not 4-byte aligned.
- retire_count  output  32  number of acknowledged instructions.

## Operation
- States: RST, FETCH, HOLD, HALT.
- RST: entered whenever reset=0 at a clock edge. Outputs: imem_req=0, instr_valid=0, instruction=32'h0, pc=PC_RESET, misalign_err=0, retire_count=0. Next state FETCH once reset=1.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready=1: instruction<=imem_rdata, -> HOLD. Otherwise remain; pc/addr stable, no request abandonment.
- HOLD: instr_valid=1, imem_req=0; instruction and pc stable. On instr_ack=1:
  - branch_taken=0: pc<=pc+4.
  - branch_taken=1: target=pc+(immediate<<1); if target[1:0]==0 then pc<=target else misalign_err<=1, pc unchanged, -> HALT.
  - retire_count<=retire_count+1 (both cases, including misaligned branch); -> FETCH unless HALT.
- HALT: imem_req=0, instr_valid=0, misalign_err=1; exit only by reset.
- Arithmetic: all PC math modulo 2^64; pc+4 from 64'hFFFF_FFFF_FFFF_FFFC wraps to 0; negative immediates (two's complement) give backward branches. immediate<<1 drops bit 63.
- retire_count wraps 32'hFFFF_FFFF -> 0.
- branch_taken with instr_ack=0 is ignored; instr_ack in FETCH/HALT/RST ignored.

## Timing
- Zero-wait memory (imem_ready=1 in first FETCH cycle): instr_valid=1 on the next cycle.
- N wait cycles: instr_valid rises N+1 cycles after FETCH entry.
- Ack in HOLD cycle k: pc updated and imem_req=1 in cycle k+1; instr_valid=0 in cycle k+1.
- Minimum throughput: one instruction per 2 cycles.
- First request: cycle after reset deasserts (RST occupies the cycle in which reset is released).
- Reset mid-FETCH or mid-HOLD: next edge forces RST values; pending memory response discarded; no partial update of pc or counter.
- imem_addr is a combinational copy of pc; instruction/pc change only on state-qualified edges.

## Test plan
- Reset: hold reset=0 3 cycles, PC_RESET=64'h1000 -> imem_req=0, pc=64'h1000, instr_valid=0, retire_count=0; first imem_req=1 cycle after release with imem_addr=64'h1000.
- Sequential: zero-wait memory, ack each instruction, branch_taken=0 -> pc 1000,1004,1008, instr_valid pulses every 2nd cycle, retire_count=3.
- Wait states: imem_ready low 4 cycles at addr 64'h1004 -> imem_addr held at 1004, instr_valid rises cycle 6 with instruction=imem_rdata sampled on ready.
- Branches: pc=64'h1010, immediate=64'hFFFF_FFFF_FFFF_FFF8 taken -> pc=64'h1000; immediate=64'h10 -> pc=64'h1030; pc=64'hFFFF_FFFF_FFFF_FFFC, not taken -> pc=0.
- Misalignment: pc=64'h1000, immediate=64'h3 taken -> misalign_err=1, imem_req stays 0, retire_count incremented, only reset clears.
- Reset mid-operation: reset=0 in HOLD with pc=64'h2000 -> next cycle pc=PC_RESET, instr_valid=0, retire_count=0.
